// File: rtl/uart_boot_loader_if.sv
// Byte-stream and memory-write handshake between uart_rx, the boot loader and the memory port.
interface uart_boot_loader_if;
  logic        rx_data_valid;
  logic [7:0]  rx_data;
  logic        rx_ack;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  modport master (
    input  rx_data_valid, rx_data, mem_ready,
    output rx_ack, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data_valid, rx_data, mem_ready,
    input  rx_ack, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_boot_loader.sv
// Loads a framed, XOR-checksummed program image from uart_rx into memory and
// holds the CPU in reset until a frame has loaded with a good checksum.
module uart_boot_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MAX_WORDS   = 1024,
  parameter int          TIMEOUT_CYC = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  uart_boot_loader_if.master  bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                err,
  output logic [15:0]         word_count
);

  localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] MAX_LEN  = 17'(MAX_WORDS);
  localparam logic [7:0]  MAGIC    = 8'hA5;

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERROR
  } state_t;

  state_t         state, state_nxt;
  logic [15:0]    len_q;
  logic [7:0]     len_lo_q;
  logic [1:0]     byte_idx;
  logic [7:0]     csum_q;
  logic [31:0]    word_q;
  logic [31:0]    addr_q;
  logic [TW-1:0]  tmo_q;

  logic           accept;
  logic           timed;
  logic           tmo_hit;
  logic           write_done;
  logic [15:0]    len_full;

  assign accept     = bus.rx_data_valid &&
                      (state inside {IDLE, LEN0, LEN1, DATA, CSUM, ERROR});
  assign timed      = state inside {LEN0, LEN1, DATA, CSUM};
  // Fires one cycle early so ERROR is entered exactly TIMEOUT_CYC cycles after the last byte.
  assign tmo_hit    = timed && !accept && (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign write_done = (state == WRITE) && bus.mem_ready;
  assign len_full   = {bus.rx_data, len_lo_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.rx_ack    = accept;
    bus.mem_we    = (state == WRITE);
    bus.mem_addr  = addr_q;
    bus.mem_wdata = word_q;
    done          = (state == DONE);
    err           = (state == ERROR);
    cpu_hold      = (state != DONE);
    case (state)
      IDLE:  if (accept && bus.rx_data == MAGIC) state_nxt = LEN0;
      LEN0: begin
        if (tmo_hit)     state_nxt = ERROR;
        else if (accept) state_nxt = LEN1;
      end
      LEN1: begin
        if (tmo_hit) state_nxt = ERROR;
        else if (accept) begin
          if ({1'b0, len_full} > MAX_LEN) state_nxt = ERROR;
          else if (len_full == 16'd0)     state_nxt = CSUM;
          else                            state_nxt = DATA;
        end
      end
      DATA: begin
        if (tmo_hit)                           state_nxt = ERROR;
        else if (accept && byte_idx == 2'd3)   state_nxt = WRITE;
      end
      WRITE: begin
        if (bus.mem_ready) begin
          if (({1'b0, word_count} + 17'd1) < {1'b0, len_q}) state_nxt = DATA;
          else                                              state_nxt = CSUM;
        end
      end
      CSUM: begin
        if (tmo_hit)     state_nxt = ERROR;
        else if (accept) state_nxt = (bus.rx_data == csum_q) ? DONE : ERROR;
      end
      DONE:  state_nxt = DONE;
      ERROR: if (accept && bus.rx_data == MAGIC) state_nxt = LEN0;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: word assembly, checksum, address/count and the idle-timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      len_lo_q   <= '0;
      byte_idx   <= '0;
      csum_q     <= '0;
      word_q     <= '0;
      addr_q     <= BASE_ADDR;
      tmo_q      <= '0;
      word_count <= '0;
    end else begin
      if (accept || !(timed || state == WRITE)) tmo_q <= '0;
      else if (timed)                           tmo_q <= tmo_q + 1'b1;

      if (accept) begin
        case (state)
          IDLE, ERROR: begin
            if (bus.rx_data == MAGIC) begin
              word_count <= '0;
              csum_q     <= '0;
              addr_q     <= BASE_ADDR;
              byte_idx   <= '0;
            end
          end
          LEN0: len_lo_q <= bus.rx_data;
          LEN1: begin
            len_q    <= len_full;
            byte_idx <= '0;
          end
          DATA: begin
            word_q   <= {bus.rx_data, word_q[31:8]};
            csum_q   <= csum_q ^ bus.rx_data;
            byte_idx <= byte_idx + 2'd1;
          end
          default: ;
        endcase
      end

      if (write_done) begin
        addr_q <= addr_q + 32'd4;
        if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: directed frames, with a write scoreboard
// fed by the stimulus and drained by an independent memory-port monitor.
module tb_uart_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_1000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] word_count;

  uart_boot_loader_if bus ();

  uart_boot_loader #(
    .BASE_ADDR  (BASE),
    .MAX_WORDS  (1024),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err),
    .word_count(word_count)
  );

  int          n_cmp;
  int          n_fail;
  wr_t         exp_q[$];
  logic [7:0]  seq_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic expectWrite(input logic [31:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Present a byte and hold it until the loader acks it (bounded wait).
  task automatic applyStimulus(input logic [7:0] b);
    bit acked;
    acked = 1'b0;
    bus.rx_data_valid = 1'b1;
    bus.rx_data       = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rx_ack) begin
        acked = 1'b1;
        break;
      end
    end
    if (!acked) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL ack_timeout: byte %h never acked, expected ack", b);
    end
    @(posedge clk);
    #1;
    bus.rx_data_valid = 1'b0;
  endtask

  task automatic sendSeq();
    foreach (seq_q[i]) applyStimulus(seq_q[i]);
  endtask

  task automatic sendNoAck(input logic [7:0] b, input int cycles);
    bus.rx_data_valid = 1'b1;
    bus.rx_data       = b;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput("no_ack_after_done", {31'd0, bus.rx_ack}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.rx_data_valid = 1'b0;
  endtask

  task automatic checkStatus(input string tag, input logic e_done, input logic e_err,
                             input logic e_hold, input logic [15:0] e_wc);
    checkOutput({tag, "_done"},     {31'd0, done},     {31'd0, e_done});
    checkOutput({tag, "_err"},      {31'd0, err},      {31'd0, e_err});
    checkOutput({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, e_hold});
    checkOutput({tag, "_wcount"},   {16'd0, word_count}, {16'd0, e_wc});
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_rx_ack"},    {31'd0, bus.rx_ack}, 32'd0);
    checkOutput({tag, "_mem_we"},    {31'd0, bus.mem_we}, 32'd0);
    checkOutput({tag, "_mem_addr"},  bus.mem_addr, BASE);
    checkOutput({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    checkStatus(tag, 1'b0, 1'b0, 1'b1, 16'd0);
  endtask

  task automatic doReset();
    bus.rx_data_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Memory-port monitor: every accepted write must match the head of the scoreboard.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_we && bus.mem_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL unexpected_write: got addr %h data %h, expected no write",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
            n_fail++;
            $display("[TB] FAIL mem_write: got addr %h data %h, expected addr %h data %h",
                     bus.mem_addr, bus.mem_wdata, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    bus.rx_data_valid = 1'b0;
    bus.rx_data       = 8'h00;
    bus.mem_ready     = 1'b1;
    rst               = 1'b1;
    #3;
    checkReset("reset");
    doReset();

    $display("[TB] noise bytes in IDLE");
    seq_q = {8'h00, 8'hFF};
    sendSeq();
    checkStatus("noise", 1'b0, 1'b0, 1'b1, 16'd0);

    $display("[TB] good frame");
    expectWrite(BASE, 32'h1234_5678);
    expectWrite(BASE + 32'd4, 32'hDEAD_BEEF);
    seq_q = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    sendSeq();
    checkStatus("good", 1'b1, 1'b0, 1'b0, 16'd2);
    sendNoAck(8'hA5, 4);
    checkStatus("good_after", 1'b1, 1'b0, 1'b0, 16'd2);
    doReset();

    $display("[TB] bad checksum then reload");
    expectWrite(BASE, 32'h1234_5678);
    expectWrite(BASE + 32'd4, 32'hDEAD_BEEF);
    seq_q = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B};
    sendSeq();
    checkStatus("badcsum", 1'b0, 1'b1, 1'b1, 16'd2);
    expectWrite(BASE, 32'h1234_5678);
    expectWrite(BASE + 32'd4, 32'hDEAD_BEEF);
    seq_q[11] = 8'h2A;
    sendSeq();
    checkStatus("reload", 1'b1, 1'b0, 1'b0, 16'd2);
    doReset();

    $display("[TB] length boundaries");
    seq_q = {8'hA5, 8'h00, 8'h00, 8'h00};
    sendSeq();
    checkStatus("len0", 1'b1, 1'b0, 1'b0, 16'd0);
    doReset();
    seq_q = {8'hA5, 8'h01, 8'h04};
    sendSeq();
    checkStatus("len1025", 1'b0, 1'b1, 1'b1, 16'd0);
    doReset();
    seq_q = {8'hA5, 8'h00, 8'h04};
    sendSeq();
    checkStatus("len1024", 1'b0, 1'b0, 1'b1, 16'd0);
    doReset();

    $display("[TB] memory back-pressure");
    bus.mem_ready = 1'b0;
    expectWrite(BASE, 32'h1234_5678);
    expectWrite(BASE + 32'd4, 32'hDEAD_BEEF);
    seq_q = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    sendSeq();
    bus.rx_data_valid = 1'b1;
    bus.rx_data       = 8'hEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_mem_we",    {31'd0, bus.mem_we}, 32'd1);
      checkOutput("bp_mem_addr",  bus.mem_addr, BASE);
      checkOutput("bp_mem_wdata", bus.mem_wdata, 32'h1234_5678);
      checkOutput("bp_rx_ack",    {31'd0, bus.rx_ack}, 32'd0);
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b1;
    seq_q = {8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    sendSeq();
    checkStatus("bp", 1'b1, 1'b0, 1'b0, 16'd2);
    doReset();

    $display("[TB] inter-byte timeout");
    seq_q = {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    sendSeq();
    repeat (99) @(posedge clk);
    #1;
    checkOutput("tmo_before", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("tmo_at", {31'd0, err}, 32'd1);
    applyStimulus(8'hA5);
    checkOutput("tmo_clear", {31'd0, err}, 32'd0);
    doReset();

    $display("[TB] reset mid-frame");
    seq_q = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56};
    sendSeq();
    rst = 1'b1;
    #2;
    checkReset("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    expectWrite(BASE, 32'h1234_5678);
    expectWrite(BASE + 32'd4, 32'hDEAD_BEEF);
    seq_q = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    sendSeq();
    checkStatus("after_rst", 1'b1, 1'b0, 1'b0, 16'd2);

    repeat (3) @(posedge clk);
    checkOutput("writes_left", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
Serial program loader that sits between uart_rx and the instruction/data memory write port. It consumes framed bytes from the receiver, assembles little-endian 32-bit words, and writes them sequentially into memory starting at BASE_ADDR. It holds the CPU pipeline in reset until a frame completes with a valid checksum, then releases the CPU and leaves the UART to software.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written
MAX_WORDS, 1024, largest legal frame length in words
TIMEOUT_CYC, 1_000_000, maximum idle cycles between bytes inside a frame; counter width is $clog2(TIMEOUT_CYC+1)

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  asynchronous, active-high reset
rx_data_valid  input  1  uart_rx has a received byte pending
rx_data  input  8  pending byte
rx_ack  output  1  one-cycle pulse; the byte on rx_data is consumed this cycle
mem_we  output  1  memory write request
mem_addr  output  32  word-aligned write address
mem_wdata  output  32  write data
mem_ready  input  1  memory accepts the write this cycle
cpu_hold  output  1  1 = pipeline held in reset
done  output  1  frame loaded and checksum verified
err  output  1  frame aborted (length, checksum or timeout)
word_count  output  16  words written in the current or last frame

Behaviour:
- Reset values: rx_ack=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, done=0, err=0, word_count=0, state=IDLE. Reset asserted mid-frame returns to IDLE immediately. Any partial word is discarded and no write is issued.
- Frame format: 0xA5, LEN_lo, LEN_hi (word count N, 16-bit LE), N*4 data bytes (each word LE, first byte = bits[7:0]), then CSUM = XOR of all data bytes. Magic and length bytes are not included in CSUM.
- A byte is accepted when rx_data_valid=1 in a byte-accepting state. rx_ack pulses in that same cycle. At most one byte is accepted per cycle.
- States:
  - IDLE: accepts bytes. 0xA5 -> LEN0 and clears word_count, CSUM accumulator and mem_addr (to BASE_ADDR). Any other byte is acked and discarded.
  - LEN0: accepts LEN_lo -> LEN1.
  - LEN1: accepts LEN_hi. If N > MAX_WORDS -> ERROR. If N == 0 -> CSUM. Otherwise -> DATA with byte index 0.
  - DATA: accepts bytes, shifts each into the word and XORs it into the accumulator. On the 4th byte -> WRITE.
  - WRITE: accepts no bytes (rx_ack=0). mem_we=1, with mem_addr/mem_wdata stable until a cycle with mem_ready=1. In that cycle the write completes. The next cycle mem_we=0, mem_addr+=4 and word_count+=1, then -> DATA if word_count < N, else -> CSUM.
  - CSUM: accepts one byte. If it matches the accumulator -> DONE, else -> ERROR.
  - DONE: done=1, cpu_hold=0, rx_ack held 0 so that all later bytes are left for software. The loader stays in DONE until rst.
  - ERROR: err=1, cpu_hold=1, done=0. Accepts and discards bytes. 0xA5 clears err and -> LEN0.
- Latency: mem_we rises in the cycle after the 4th byte of a word is acked. done rises in the cycle after a good CSUM byte is acked.
- Timeout: the counter runs in LEN0, LEN1, DATA and CSUM. It clears on every accepted byte. Reaching TIMEOUT_CYC -> ERROR. The counter is frozen in WRITE (memory back-pressure is not a timeout).
- Simultaneous events: a byte pending during WRITE waits; it is not dropped and not acked. mem_ready is ignored when mem_we=0.
- Writes that completed before an ERROR are not undone.
- word_count saturates at its width; legal N ≤ MAX_WORDS keeps it in range.

Test Plan:
1. Good frame: send A5 02 00 78 56 34 12 EF BE AD DE 2A with mem_ready=1 -> exactly two writes: 0x12345678 at BASE_ADDR and 0xDEADBEEF at BASE_ADDR+4. Then done=1, cpu_hold=0, word_count=2, and rx_ack=0 for all later bytes.
2. Bad checksum: same frame with final byte 0x2B -> both writes occur, then err=1, done=0, cpu_hold=1. Resending the good frame from 0xA5 -> done=1.
3. Length boundaries: A5 00 00 00 -> done=1 with no mem_we. With MAX_WORDS=1024, A5 01 04 -> err=1 immediately after LEN_hi, with no writes.
4. Back-pressure: hold mem_ready=0 for 3 cycles during the first write while the next byte is pending -> mem_we/mem_addr/mem_wdata stable, rx_ack=0 throughout. After mem_ready=1, the byte is acked in a later cycle and all data matches test 1.
5. Timeout: TIMEOUT_CYC=100, send A5 01 00 11 22 then stop -> err=1 exactly 100 cycles after the 0x22 ack, with no write. A following 0xA5 clears err.
6. Noise and reset: 00 FF in IDLE -> both acked, state stays IDLE. Assert rst after 2 data bytes -> all outputs return to their reset values, no write issued, and a new frame loads correctly.
